// File: rtl/wb_slv_pkg.sv
// -----------------------------------------------------------------------------
// wb_slv_pkg
// Shared definitions for the Wishbone B3 slave memory: cycle-type and
// burst-type encodings, FSM state type, error data word and a byte-lane
// merge helper.
// -----------------------------------------------------------------------------
package wb_slv_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_slv_state_t;

   // Replace the bytes of old_w selected by sel with the bytes of new_w.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_slv_burst_addr.sv
// -----------------------------------------------------------------------------
// wb_slv_burst_addr
// Combinational next-beat word address for Wishbone incrementing bursts.
// Linear bursts increment modulo 2^MEM_AW; wrap4/8/16 increment only the
// low 2/3/4 address bits and keep the upper bits.
//   addr_i       current word address
//   bte_i        burst type extension
//   next_addr_o  address of the following beat
// -----------------------------------------------------------------------------
module wb_slv_burst_addr
   import wb_slv_pkg::*;
#(
   parameter int MEM_AW = 12
) (
   input  logic [MEM_AW-1:0] addr_i,
   input  logic [1:0]        bte_i,
   output logic [MEM_AW-1:0] next_addr_o
);

   logic [MEM_AW-1:0] mask;
   logic [MEM_AW-1:0] inc;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      mask = '1;
      case (bte_i)
         BTE_LINEAR: mask = '1;
         BTE_WRAP4:  mask = MEM_AW'(3);
         BTE_WRAP8:  mask = MEM_AW'(7);
         BTE_WRAP16: mask = MEM_AW'(15);
         default:    mask = '1;
      endcase
      inc         = addr_i + MEM_AW'(1);
      // Bits outside the wrap window come from the old address, bits inside from the increment.
      next_addr_o = (addr_i & ~mask) | (inc & mask);
   end

endmodule

// File: rtl/wb_slave_mem.sv
// -----------------------------------------------------------------------------
// wb_slave_mem
// Wishbone B3 slave with an internal 2^MEM_AW x 32-bit word memory,
// programmable wait states before the first ack, byte-lane writes and
// registered-feedback incrementing bursts (linear / wrap4 / wrap8 / wrap16).
//
// Ports:
//   sys_clk, RESETN       clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i    bus cycle / strobe (request = cyc & stb)
//   wb_we_i               1 = write
//   wb_addr_i [AW]        word address
//   wb_sel_i  [4]         byte lane enables
//   wb_dat_i  [32]        write data
//   wb_cti_i  [3]         cycle type (classic / incrementing / end-of-burst)
//   wb_bte_i  [2]         burst type (linear / wrap4 / wrap8 / wrap16)
//   cfg_wait_i [4]        wait states before the first ack, clamped to MAX_WAIT
//   wb_dat_o  [32]        read data, registered
//   wb_ack_o, wb_err_o    acknowledge / error, decoded from registered state
//   busy_o                FSM not idle
//
// Configuration macro WB_SLV_ERR_EN: when defined, addresses with bits set
// above MEM_AW are answered with wb_err_o and ERR_DATA instead of aliasing.
//
// Write data and byte lanes are taken from the bus during each ack cycle,
// which is exactly what the master holds for the beat being acknowledged.
// -----------------------------------------------------------------------------
module wb_slave_mem
   import wb_slv_pkg::*;
#(
   parameter int AW       = 30,
   parameter int MEM_AW   = 12,
   parameter int MAX_WAIT = 15
) (
   input  logic          sys_clk,
   input  logic          RESETN,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [AW-1:0] wb_addr_i,
   input  logic [3:0]    wb_sel_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   input  logic [3:0]    cfg_wait_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          busy_o
);

   localparam int DEPTH = 1 << MEM_AW;

   logic [31:0]       mem [DEPTH];

   wb_slv_state_t     state_q;
   logic [MEM_AW-1:0] addr_q;
   logic              we_q;
   logic [3:0]        cnt_q;
   logic              oob_q;
   logic [31:0]       dat_o_q;

   logic              req;
   logic [3:0]        wait_n;
   logic [MEM_AW-1:0] next_addr;
   logic [MEM_AW-1:0] rd_addr;
   logic              rd_oob;
   logic [31:0]       rd_word;
   logic [31:0]       rd_data;
   logic              mem_wr;
   logic              burst_go;
   logic              oob_req;
   logic              oob_step;

   assign req      = wb_cyc_i & wb_stb_i;
   assign wait_n   = (int'(cfg_wait_i) > MAX_WAIT) ? 4'(MAX_WAIT) : cfg_wait_i;
   assign burst_go = req & (wb_cti_i == CTI_INCR);
   assign mem_wr   = (state_q == ACK) & we_q & ~oob_q & req;

`ifdef WB_SLV_ERR_EN
   assign oob_req  = |wb_addr_i[AW-1:MEM_AW];
   // A linear step from the top word carries out of the memory range.
   assign oob_step = oob_q | ((wb_bte_i == BTE_LINEAR) & (&addr_q));
   assign wb_err_o = (state_q == ACK) & oob_q;
`else
   logic unused_hi_addr;
   assign unused_hi_addr = ^wb_addr_i[AW-1:MEM_AW];
   assign oob_req  = 1'b0;
   assign oob_step = 1'b0;
   assign wb_err_o = 1'b0;
`endif

   assign wb_ack_o = (state_q == ACK) & ~oob_q;
   assign busy_o   = (state_q != IDLE);
   assign wb_dat_o = dat_o_q;

   wb_slv_burst_addr #(.MEM_AW(MEM_AW)) u_burst_addr (
      .addr_i      (addr_q),
      .bte_i       (wb_bte_i),
      .next_addr_o (next_addr)
   );

   // Read port: the address of whichever beat enters ACK on the next edge.
   always_comb begin
      rd_addr = wb_addr_i[MEM_AW-1:0];
      rd_oob  = oob_req;
      if (state_q == WAIT) begin
         rd_addr = addr_q;
         rd_oob  = oob_q;
      end else if (state_q == ACK) begin
         rd_addr = next_addr;
         rd_oob  = oob_step;
      end
      rd_word = mem[rd_addr];
      // Bypass a write committing on the same edge to the word being read.
      if (mem_wr && (rd_addr == addr_q)) rd_word = byte_merge(rd_word, wb_dat_i, wb_sel_i);
      rd_data = rd_oob ? ERR_DATA : rd_word;
   end

   // NOTE: the memory array has no reset so it maps onto RAM; contents survive RESETN.
   always_ff @(posedge sys_clk) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) mem[addr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         oob_q   <= 1'b0;
         dat_o_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q <= wb_addr_i[MEM_AW-1:0];
                  we_q   <= wb_we_i;
                  oob_q  <= oob_req;
                  if (wait_n == 4'd0) begin
                     state_q <= ACK;
                     if (!wb_we_i || oob_req) dat_o_q <= rd_data;
                  end else begin
                     cnt_q   <= wait_n;
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (!req) begin
                  state_q <= IDLE;
               end else if (cnt_q == 4'd1) begin
                  state_q <= ACK;
                  if (!we_q || oob_q) dat_o_q <= rd_data;
               end
            end
            ACK: begin
               case (wb_cti_i)
                  CTI_INCR: begin
                     if (burst_go) begin
                        addr_q <= next_addr;
                        we_q   <= wb_we_i;
                        oob_q  <= oob_step;
                        if (!wb_we_i || oob_step) dat_o_q <= rd_data;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
                  CTI_CLASSIC, CTI_EOB: state_q <= IDLE;
                  default:              state_q <= IDLE;
               endcase
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_mem
// Directed bench for wb_slave_mem: classic writes/reads, wait-state latency,
// byte lanes, linear and wrap4 bursts, abort, reset mid-burst and
// out-of-range addressing (aliasing, or errors under WB_SLV_ERR_EN).
// -----------------------------------------------------------------------------
module tb_wb_slave_mem;
   import wb_slv_pkg::*;

   localparam int AW = 30;

   logic          sys_clk = 1'b0;
   logic          RESETN;
   logic          wb_cyc_i, wb_stb_i, wb_we_i;
   logic [AW-1:0] wb_addr_i;
   logic [3:0]    wb_sel_i;
   logic [31:0]   wb_dat_i;
   logic [2:0]    wb_cti_i;
   logic [1:0]    wb_bte_i;
   logic [3:0]    cfg_wait_i;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_o, wb_err_o, busy_o;

   int compares = 0;
   int fails    = 0;

   logic [31:0] bdat [4];

   always #5 sys_clk = ~sys_clk;

   wb_slave_mem dut (
      .sys_clk    (sys_clk),
      .RESETN     (RESETN),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_we_i    (wb_we_i),
      .wb_addr_i  (wb_addr_i),
      .wb_sel_i   (wb_sel_i),
      .wb_dat_i   (wb_dat_i),
      .wb_cti_i   (wb_cti_i),
      .wb_bte_i   (wb_bte_i),
      .cfg_wait_i (cfg_wait_i),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_o   (wb_ack_o),
      .wb_err_o   (wb_err_o),
      .busy_o     (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Classic cycle; called and returns #1 after a rising edge.
   task automatic single(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat,
                         output int busy_cnt, output logic acked, output logic erred);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_addr_i = a;
      wb_dat_i = d; wb_sel_i = sel; wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
      lat = 0; busy_cnt = 0;
      do begin
         @(posedge sys_clk); #1;
         lat++;
         if (busy_o) busy_cnt++;
      end while (!wb_ack_o && !wb_err_o && lat < 40);
      acked = wb_ack_o; erred = wb_err_o; rdata = wb_dat_o;
      @(posedge sys_clk); #1;
      if (busy_o) busy_cnt++;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] rd; int lat, bc; logic ak, er;
      single(1'b1, a, d, sel, rd, lat, bc, ak, er);
      check(tag, 32'(ak), 32'd1);
   endtask

   task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
      logic [31:0] r; int lat, bc; logic ak, er;
      single(1'b0, a, 32'h0, 4'hF, r, lat, bc, ak, er);
      check(tag, r, exp);
   endtask

   // Incrementing burst of n beats; write data from bdat, read results into bdat.
   task automatic burst(input logic we, input logic [AW-1:0] a, input logic [1:0] bte,
                        input int n, output int acks);
      int t;
      acks = 0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_addr_i = a; wb_sel_i = 4'hF;
      wb_bte_i = bte; wb_dat_i = bdat[0]; wb_cti_i = (n > 1) ? CTI_INCR : CTI_EOB;
      t = 0;
      do begin @(posedge sys_clk); #1; t++; end while (!wb_ack_o && t < 40);
      for (int k = 0; k < n; k++) begin
         if (wb_ack_o) acks++;
         if (!we) bdat[k] = wb_dat_o;
         @(posedge sys_clk); #1;
         if (k < n - 1) begin
            wb_dat_i  = bdat[k+1];
            wb_addr_i = a + AW'(k + 1);
            wb_cti_i  = (k + 1 == n - 1) ? CTI_EOB : CTI_INCR;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r; int lat, bc, acks; logic ak, er, ack_seen;
      logic [AW-1:0] t1_addr;

      RESETN = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_addr_i = '0; wb_sel_i = 4'h0; wb_dat_i = '0; wb_cti_i = CTI_CLASSIC;
      wb_bte_i = BTE_LINEAR; cfg_wait_i = 4'd0;
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst_dat",  wb_dat_o, 32'h0);
      check("rst_ack",  32'(wb_ack_o), 32'd0);
      check("rst_err",  32'(wb_err_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      RESETN = 1'b1;
      @(posedge sys_clk); #1;

      // 1: zero-wait write then read of the same word
`ifdef WB_SLV_ERR_EN
      t1_addr = 30'h0_0000;
`else
      t1_addr = 30'h1_0000;
`endif
      single(1'b1, t1_addr, 32'h1234_5678, 4'hF, r, lat, bc, ak, er);
      check("t1_wr_ack", 32'(ak), 32'd1);
      check("t1_wr_lat", 32'(lat), 32'd1);
      single(1'b0, t1_addr, 32'h0, 4'hF, r, lat, bc, ak, er);
      check("t1_rd_lat", 32'(lat), 32'd1);
      check("t1_rd_dat", r, 32'h1234_5678);
      check("t1_busy",   32'(bc), 32'd1);

      // 2: three wait states
      cfg_wait_i = 4'd3;
      single(1'b0, 30'h0, 32'h0, 4'hF, r, lat, bc, ak, er);
      check("t2_lat",  32'(lat), 32'd4);
      check("t2_busy", 32'(bc), 32'd4);
      check("t2_dat",  r, 32'h1234_5678);
      cfg_wait_i = 4'd0;

      // 3: byte lanes
      wr("t3_wr1", 30'h20, 32'hFFFF_FFFF, 4'hF);
      wr("t3_wr2", 30'h20, 32'h0000_0000, 4'b0101);
      rd("t3_rd", 30'h20, 32'hFF00_FF00);

      // 4: linear burst write/read across 0x3FF->0x400, then wrap4 at 0x006
      bdat[0] = 32'hA000_0001; bdat[1] = 32'hA000_0002;
      bdat[2] = 32'hA000_0003; bdat[3] = 32'hA000_0004;
      burst(1'b1, 30'h3FE, BTE_LINEAR, 4, acks);
      check("t4_wr_acks", 32'(acks), 32'd4);
      bdat[0] = '0; bdat[1] = '0; bdat[2] = '0; bdat[3] = '0;
      burst(1'b0, 30'h3FE, BTE_LINEAR, 4, acks);
      check("t4_rd_acks", 32'(acks), 32'd4);
      check("t4_rd0", bdat[0], 32'hA000_0001);
      check("t4_rd1", bdat[1], 32'hA000_0002);
      check("t4_rd2", bdat[2], 32'hA000_0003);
      check("t4_rd3", bdat[3], 32'hA000_0004);
      rd("t4_cl_400", 30'h400, 32'hA000_0003);
      bdat[0] = 32'hB000_0006; bdat[1] = 32'hB000_0007;
      bdat[2] = 32'hB000_0004; bdat[3] = 32'hB000_0005;
      burst(1'b1, 30'h006, BTE_WRAP4, 4, acks);
      check("t4_wrap_acks", 32'(acks), 32'd4);
      rd("t4_wrap_004", 30'h004, 32'hB000_0004);
      rd("t4_wrap_005", 30'h005, 32'hB000_0005);
      rd("t4_wrap_006", 30'h006, 32'hB000_0006);
      rd("t4_wrap_007", 30'h007, 32'hB000_0007);

      // 5a: abort during wait states
      wr("t5_pre", 30'h50, 32'h1111_2222, 4'hF);
      cfg_wait_i = 4'd5; ack_seen = 1'b0;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_addr_i = 30'h50;
      wb_dat_i = 32'h5555_AAAA; wb_sel_i = 4'hF; wb_cti_i = CTI_CLASSIC;
      repeat (2) begin
         @(posedge sys_clk); #1;
         if (wb_ack_o) ack_seen = 1'b1;
      end
      check("t5_wait_busy", 32'(busy_o), 32'd1);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(posedge sys_clk); #1;
      check("t5_no_ack", 32'(ack_seen | wb_ack_o), 32'd0);
      check("t5_idle",   32'(busy_o), 32'd0);
      cfg_wait_i = 4'd0;
      rd("t5_unchanged", 30'h50, 32'h1111_2222);

      // 5b: reset in the third beat of a write burst
      wr("t5_pre202", 30'h202, 32'h0BAD_F00D, 4'hF);
      rd("t5_rd202", 30'h202, 32'h0BAD_F00D);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_addr_i = 30'h200;
      wb_sel_i = 4'hF; wb_bte_i = BTE_LINEAR; wb_cti_i = CTI_INCR; wb_dat_i = 32'hC000_0000;
      @(posedge sys_clk); #1;
      check("t5_b0_ack", 32'(wb_ack_o), 32'd1);
      @(posedge sys_clk); #1;
      wb_dat_i = 32'hC000_0001; wb_addr_i = 30'h201;
      check("t5_b1_ack", 32'(wb_ack_o), 32'd1);
      @(posedge sys_clk); #1;
      wb_dat_i = 32'hC000_0002; wb_addr_i = 30'h202;
      #2 RESETN = 1'b0;
      #1;
      check("t5_rst_ack",  32'(wb_ack_o), 32'd0);
      check("t5_rst_busy", 32'(busy_o), 32'd0);
      check("t5_rst_dat",  wb_dat_o, 32'h0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = CTI_CLASSIC;
      @(posedge sys_clk); #1;
      RESETN = 1'b1;
      @(posedge sys_clk); #1;
      rd("t5_kept200", 30'h200, 32'hC000_0000);
      rd("t5_kept201", 30'h201, 32'hC000_0001);
      rd("t5_keep202", 30'h202, 32'h0BAD_F00D);

      // 6: address with bit 12 set
      wr("t6_pre0", 30'h000, 32'h1234_5678, 4'hF);
      single(1'b0, 30'h1000, 32'h0, 4'hF, r, lat, bc, ak, er);
      check("t6_not_both", 32'(ak & er), 32'd0);
`ifdef WB_SLV_ERR_EN
      check("t6_err", 32'(er), 32'd1);
      check("t6_ack", 32'(ak), 32'd0);
      check("t6_dat", r, 32'hDEAD_BEEF);
`else
      check("t6_err", 32'(er), 32'd0);
      check("t6_ack", 32'(ak), 32'd1);
      check("t6_dat", r, 32'h1234_5678);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
Synthesizable Wishbone B3 slave (responder) with an internal word-addressed memory. It is the target-side counterpart to the bench's Wishbone master tasks, which issue word-address single and burst writes and reads. It has programmable wait states, byte-lane writes, and registered-feedback incrementing bursts. It stands in for sdrc_top as a golden responder when qualifying the master bench and scoreboard, and can be instantiated behind a bus decoder.

Parameters:
AW, 30, width of wb_addr_i (word address, i.e. byte address [31:2])
MEM_AW, 12, log2 of memory depth in 32-bit words (4096 words)
MAX_WAIT, 15, upper clamp on cfg_wait_i

Ports:
sys_clk  in  1  clock
RESETN  in  1  asynchronous active-low reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  1=write
wb_addr_i  in  AW  word address
wb_sel_i  in  4  byte lane enables
wb_dat_i  in  32  write data
wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst
wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
cfg_wait_i  in  4  wait states before first ack; static during a cycle
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error; tied 0 unless WB_SLV_ERR_EN is defined
busy_o  out  1  state != IDLE

Behaviour:
- One clock domain, sys_clk. Reset is asynchronous and active-low on RESETN.
- Reset values:
  - wb_dat_o = 0, wb_ack_o = 0, wb_err_o = 0, busy_o = 0.
  - state = IDLE; internal addr/we/sel/data/count registers = 0.
  - Memory contents are not reset.
- req = wb_cyc_i & wb_stb_i.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On req, latch addr_q = wb_addr_i[MEM_AW-1:0], plus we_q, sel_q, dat_q.
  - If min(cfg_wait_i, MAX_WAIT) == 0, go to ACK. Otherwise load cnt = that value and go to WAIT.
- WAIT:
  - cnt decrements each cycle; at cnt == 1, go to ACK.
  - Latency from req sampled to ack high is 1 + N cycles for N wait states.
- ACK:
  - wb_ack_o = 1 for exactly the cycles spent in ACK. It is decoded from registered state, so it is glitch-free.
  - Write: on the clock edge leaving/holding ACK, for each byte b with sel_q[b]=1, mem[addr_q][8b+7:8b] <= dat_q byte. Bytes with sel_q[b]=0 are untouched.
  - Read: wb_dat_o is loaded with mem[addr_q] on the edge entering ACK, so it is valid for the whole ack cycle. Outside ACK, wb_dat_o holds its last value.
- Transitions out of ACK:
  - wb_cti_i == 010 and req still high: stay in ACK (zero-wait beats).
    - addr_q advances via next-address logic: linear = +1 modulo 2^MEM_AW; wrap4/8/16 = increment low 2/3/4 bits only.
    - Capture the next we/sel/dat.
    - Preload wb_dat_o = mem[next addr].
  - Otherwise (000, 111, or req low): go to IDLE. The ack drops the next cycle.
  - A fresh req in IDLE restarts the sequence, so back-to-back classic cycles have a one-cycle gap minimum.
- Write then read of the same word in consecutive classic cycles: the read returns the new data, because the write commits at the ack edge.
- Burst write immediately followed by a read of the next address: the next-address preload must observe the write if the addresses match, so apply the write bypass.
- Abort: req low while in WAIT goes to IDLE next cycle. No write, no ack.
- Reset asserted mid-burst: immediate return to IDLE with outputs at reset values. Partially written beats stay in memory.
- cfg_wait_i > MAX_WAIT is clamped to MAX_WAIT.
- Address bits above MEM_AW alias (ignored) unless WB_SLV_ERR_EN is defined.
- wb_ack_o and wb_err_o are never high together.

Optional Feature:
WB_SLV_ERR_EN
- Defined: on request latch, flag oob_q = |wb_addr_i[AW-1:MEM_AW].
  - In ACK with oob_q=1, assert wb_err_o instead of wb_ack_o.
  - No memory write; wb_dat_o is forced to 32'hDEAD_BEEF.
  - A burst that steps out of range errors per beat, and oob_q is re-evaluated on each advanced address (linear only).
- Not defined: wb_err_o is tied 0 and addresses alias.

Decomposition:
- Package wb_slv_pkg:
  - CTI_CLASSIC/CTI_INCR/CTI_EOB localparams.
  - BTE_LINEAR/WRAP4/WRAP8/WRAP16 localparams.
  - typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_slv_state_t.
  - ERR_DATA constant 32'hDEAD_BEEF.
- Sub-module wb_slv_burst_addr: combinational next-address computation from addr and bte. Instantiated once.

Test Plan:
1. cfg_wait_i=0; write 0x1234_5678 to word 0x1_0000 (sel=F), then read it -> ack 1 cycle after req; read data 0x1234_5678.
2. cfg_wait_i=3; single read -> ack exactly 4 cycles after req sampled; busy_o high 4 cycles.
3. Write 0xFFFF_FFFF, then write 0x0000_0000 with sel=0101, then read -> 0xFF00_FF00.
4. Incrementing burst of 4 writes at word 0x3FE (linear, MEM_AW=12) with cti 010,010,010,111; then a 4-beat read burst -> 4 consecutive ack cycles each; data from 0x3FE..0x401 matches; write wrap4 at 0x006 lands at 0x006,0x007,0x004,0x005.
5. cfg_wait_i=5; drop cyc after 2 cycles -> no ack; target word unchanged; state IDLE next cycle. Then assert RESETN=0 mid-burst -> ack/dat/busy go 0 asynchronously.
6. WB_SLV_ERR_EN: read word 0x1000 (bit 12 set) -> wb_err_o=1, wb_ack_o=0, data 0xDEAD_BEEF. Without the macro -> ack, with data aliased from word 0x000.
